int32_block_scale_calibrator: RTL

Upstream stage of the INT32->INT8 weight compressor. Buffers one block of BLOCK_LEN signed INT32 weights and tracks their maximum magnitude. It then computes the smallest power-of-two scale that keeps the rounded block maximum within INT8 range. It replays the block with that one-hot scale attached, so the downstream compressor rounds and saturates each word without clipping the block maximum.

---
 rtl/int8_quant_pkg.sv | 14 +
 rtl/scale_shift_encoder.sv | 35 +++
 rtl/int32_block_scale_calibrator.sv | 108 ++++++++++
 3 files changed

// File: rtl/int8_quant_pkg.sv
// Shared constants and types for the INT32->INT8 weight compression path.
package int8_quant_pkg;

    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;
    localparam int MAX_SHIFT = 25;

    typedef enum logic [1:0] {
        FILL,
        CALC,
        DRAIN
    } calib_state_t;

endpackage

// File: rtl/scale_shift_encoder.sv
// Maps a block's max magnitude to the smallest power-of-two shift that keeps
// the rounded maximum inside INT8 range.
module scale_shift_encoder
    import int8_quant_pkg::*;
(
    input  logic [31:0] maxabs,
    output logic [4:0]  shift,
    output logic [31:0] scale
);

    logic [4:0]  msb;
    logic [5:0]  base;
    logic [32:0] rnd;
    logic [4:0]  s_raw;

    always_comb begin
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (maxabs[i]) msb = 5'(i);
        end
        base  = '0;
        rnd   = '0;
        s_raw = '0;
        if (maxabs > 32'(INT8_MAX)) begin
            base = {1'b0, msb} - 6'd6;
            // Half-up rounding can carry the magnitude to 128; bump the shift.
            rnd  = ({1'b0, maxabs} + (33'd1 << (base - 6'd1))) >> base;
            if (rnd > 33'(INT8_MAX)) s_raw = base[4:0] + 5'd1;
            else                     s_raw = base[4:0];
        end
        shift = (s_raw > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : s_raw;
        scale = 32'h1 << shift;
    end

endmodule

// File: rtl/int32_block_scale_calibrator.sv
// Buffers one block of INT32 weights, derives a shared power-of-two scale,
// then replays the block with that scale attached.
module int32_block_scale_calibrator
    import int8_quant_pkg::*;
#(
    parameter int BLOCK_LEN = 16,
    parameter int ADDR_W    = $clog2(BLOCK_LEN)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_scale,
    output logic [4:0]  out_shift,
    output logic        out_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLOCK_LEN - 1);

    calib_state_t state, state_nx;

    logic [31:0]       mem [BLOCK_LEN];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       maxabs;
    logic [31:0]       abs_in;
    logic              wr_en;
    logic              rd_en;
    logic              calc_en;
    logic [4:0]        enc_shift;
    logic [31:0]       enc_scale;

    // Unsigned magnitude: -2^31 maps to 2^31 without overflow.
    assign abs_in = in_data[31] ? (~in_data + 32'd1) : in_data;

    scale_shift_encoder u_enc (
        .maxabs (maxabs),
        .shift  (enc_shift),
        .scale  (enc_scale)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        calc_en   = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_IDX) state_nx = CALC;
                end
            end
            CALC: begin
                calc_en  = 1'b1;
                state_nx = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rd_en = 1'b1;
                    if (rd_ptr == LAST_IDX) state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            maxabs    <= '0;
            out_shift <= '0;
            out_scale <= 32'h1;
        end else begin
            state <= state_nx;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (abs_in > maxabs) maxabs <= abs_in;
            end
            if (calc_en) begin
                out_shift <= enc_shift;
                out_scale <= enc_scale;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (rd_ptr == LAST_IDX) maxabs <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    assign out_data = (state == DRAIN) ? mem[rd_ptr] : '0;
    assign out_last = (state == DRAIN) && (rd_ptr == LAST_IDX);

endmodule
